mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WORDS, default 64, number of 32-bit words in backing RAM (byte space 4*WORDS = 256).
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
REQ-004 Req  in  1  CPU request strobe, held high until Ready.
REQ-005 Wr  in  1  1 = store, 0 = load.
REQ-006 Size  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-007 Address  in  32  byte address; bits above log2(4*WORDS) ignored (wrap).
REQ-008 Datain  in  32  store data, right-justified for half/byte.
REQ-009 Ready  out  1  one-cycle completion pulse.
REQ-010 Dataout  out  32  load data, right-justified, zero-extended; valid only while Ready.
REQ-011 Err  out  1  misaligned/illegal-size flag, valid only while Ready.

Function
REQ-012 FSM states: IDLE, RD, MERGE, WR, RESP; reset state IDLE.
REQ-013 IDLE: Req=1 captures Wr, Size, Address, Datain into internal registers at that edge; inputs are ignored in every other state.
REQ-014 Error check at capture: Size=11, half with Address[0]=1, or word with Address[1:0]!=00 -> next state RESP with Err=1, no RAM write, Dataout=0.
REQ-015 Load: IDLE->RD->RESP; RAM read issued in RD; Ready high 2 cycles after the capture edge.
REQ-016 Word store: IDLE->WR->RESP; full-word RAM write in WR; Ready 2 cycles after capture.
REQ-017 Sub-word store (read-modify-write): IDLE->RD->MERGE->WR->RESP; Ready 4 cycles after capture; untouched bytes of the word preserved.
REQ-018 Byte order big-endian: byte offset 0 = bits 31:24; halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-019 Load extraction: byte -> {24'b0, selected byte}; half -> {16'b0, selected half}; word unchanged.
REQ-020 RESP lasts exactly one cycle, then IDLE; Ready, Err, Dataout are registered outputs.
REQ-021 Req still high in the cycle after RESP starts a new transaction (back-to-back allowed); no request is lost or duplicated.
REQ-022 Word index = Address[log2(4*WORDS)-1:2]; addresses beyond range wrap modulo byte space.
REQ-023 Store then load to the same address returns the stored value; no read-during-write hazard is exposed to the CPU.

Reset
REQ-024 Reset low -> state IDLE, Ready=0, Err=0, Dataout=0, captured registers cleared, immediately and asynchronously.
REQ-025 Reset mid-transaction aborts it: no Ready pulse, pending RAM write is not performed, RAM contents otherwise retained.
REQ-026 RAM contents are not cleared by reset.

Structure
REQ-027 Shared package holds Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE), FSM state encoding, and WORDS default.
REQ-028 One sub-module, mem_word_ram: synchronous single-port WORDS x 32 RAM, registered read, write-enable, no reset.
REQ-029 Byte-lane merge/extract logic stays in mem_responder, combinational from captured registers.

Verification
REQ-030 Word store 0x12345678 at 0x10, then word load 0x10 -> Dataout=0x12345678, Err=0, Ready 2 cycles after each capture.
REQ-031 After REQ-030, byte store 0xAB at 0x12 -> Ready 4 cycles after capture; word load 0x10 -> 0x1234AB78; byte load 0x12 -> 0x000000AB.
REQ-032 Half store 0xBEEF at 0x16 -> half load 0x16 = 0x0000BEEF; word load 0x14 shows 0xBEEF in bits 15:0, bits 31:16 unchanged.
REQ-033 Word load 0x11, half store 0x13, Size=11 -> each Err=1, Dataout=0, RAM unchanged (word load 0x10 still 0x1234AB78).
REQ-034 Req held high across four back-to-back loads -> exactly four Ready pulses, correct data in order.
REQ-035 Reset asserted in MERGE of a byte store to 0x10 -> no Ready, Dataout=0 immediately; after release word load 0x10 returns pre-store value.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared encodings and access checks for mem_responder
package mem_responder_pkg;

  localparam int WORDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Illegal size or an address not aligned to the access width.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_WORD: return off != 2'b00;
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - single-port WORDS x 32 RAM with registered read
module mem_word_ram #(
  parameter int WORDS = 64,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU load/store responder over a word RAM, big-endian
// byte lanes, read-modify-write for sub-word stores.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] address,
  input  logic [31:0] datain,
  output logic        ready,
  output logic [31:0] dataout,
  output logic        err
);

  localparam int AW = $clog2(4 * WORDS);
  localparam int IW = AW - 2;

  state_e        state;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          err_q;
  logic [31:0]   merge_q;

  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [4:0]    byte_sh;
  logic [4:0]    half_sh;
  logic [31:0]   load_data;
  logic [31:0]   merged;

  logic          unused_addr;
  assign unused_addr = ^address[31:AW];

  assign ram_we    = (state == ST_WR);
  assign ram_wdata = (size_q == SZ_WORD) ? data_q : merge_q;

  mem_word_ram #(.WORDS(WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[AW-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Offset 0 is the most significant lane, so shift = (3 - off) * 8 for bytes.
  always_comb begin
    byte_sh   = {~addr_q[1:0], 3'b000};
    half_sh   = {~addr_q[1], 4'b0000};
    load_data = ram_rdata;
    merged    = ram_rdata;
    case (size_q)
      SZ_BYTE: begin
        load_data = {24'b0, 8'(ram_rdata >> byte_sh)};
        merged    = (ram_rdata & ~(32'h0000_00ff << byte_sh))
                  | ({24'b0, data_q[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_data = {16'b0, 16'(ram_rdata >> half_sh)};
        merged    = (ram_rdata & ~(32'h0000_ffff << half_sh))
                  | ({16'b0, data_q[15:0]} << half_sh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      dataout <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            wr_q   <= wr;
            size_q <= size;
            addr_q <= address[AW-1:0];
            data_q <= datain;
            err_q  <= access_bad(size, address[1:0]);
            if (access_bad(size, address[1:0])) begin
              state <= ST_RESP;
            end else if (wr && size == SZ_WORD) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD:    state <= wr_q ? ST_MERGE : ST_RESP;
        ST_MERGE: begin
          merge_q <= merged;
          state   <= ST_WR;
        end
        ST_WR:    state <= ST_RESP;
        ST_RESP: begin
          ready   <= 1'b1;
          err     <= err_q;
          dataout <= (err_q || wr_q) ? 32'h0 : load_data;
          state   <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] address;
  logic [31:0] datain;
  logic        ready;
  logic [31:0] dataout;
  logic        err;

  int total;
  int bad;

  mem_responder #(.WORDS(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .address (address),
    .datain  (datain),
    .ready   (ready),
    .dataout (dataout),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] dout,
                     output logic e);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; address = a; datain = d;
    @(posedge clk);
    lat = -1; dout = 32'h0; e = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = c; dout = dataout; e = err;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic op(input string tag, input logic w, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                    input logic [31:0] exp_data, input logic exp_err);
    int          lat;
    logic [31:0] dout;
    logic        e;
    txn(w, sz, a, d, lat, dout, e);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, dout, exp_data);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, ready}, 32'h0);
  endtask

  logic [31:0] b2b_addr [4];
  logic [1:0]  b2b_size [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    int n;
    total = 0; bad = 0;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; address = 32'h0; datain = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_dout", dataout, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // word store / load round trip
    op("st_w10", 1'b1, 2'b00, 32'h10, 32'h1234_5678, 2, 32'h0, 1'b0);
    op("ld_w10", 1'b0, 2'b00, 32'h10, 32'h0, 2, 32'h1234_5678, 1'b0);

    // byte read-modify-write
    op("st_b12", 1'b1, 2'b10, 32'h12, 32'h0000_00ab, 4, 32'h0, 1'b0);
    op("ld_w10b", 1'b0, 2'b00, 32'h10, 32'h0, 2, 32'h1234_ab78, 1'b0);
    op("ld_b12", 1'b0, 2'b10, 32'h12, 32'h0, 2, 32'h0000_00ab, 1'b0);
    op("ld_b10", 1'b0, 2'b10, 32'h10, 32'h0, 2, 32'h0000_0012, 1'b0);
    op("ld_b13", 1'b0, 2'b10, 32'h13, 32'h0, 2, 32'h0000_0078, 1'b0);
    op("ld_h10", 1'b0, 2'b01, 32'h10, 32'h0, 2, 32'h0000_1234, 1'b0);

    // halfword read-modify-write into the low half
    op("st_w14", 1'b1, 2'b00, 32'h14, 32'h5566_7788, 2, 32'h0, 1'b0);
    op("st_h16", 1'b1, 2'b01, 32'h16, 32'hffff_beef, 4, 32'h0, 1'b0);
    op("ld_h16", 1'b0, 2'b01, 32'h16, 32'h0, 2, 32'h0000_beef, 1'b0);
    op("ld_w14", 1'b0, 2'b00, 32'h14, 32'h0, 2, 32'h5566_beef, 1'b0);

    // misaligned and illegal accesses
    op("err_w11", 1'b0, 2'b00, 32'h11, 32'h0, 1, 32'h0, 1'b1);
    op("err_h13", 1'b1, 2'b01, 32'h13, 32'h0000_dead, 1, 32'h0, 1'b1);
    op("err_sz3", 1'b1, 2'b11, 32'h10, 32'hffff_ffff, 1, 32'h0, 1'b1);
    op("ld_w10c", 1'b0, 2'b00, 32'h10, 32'h0, 2, 32'h1234_ab78, 1'b0);

    // address wrap beyond the 256-byte space
    op("st_wrap", 1'b1, 2'b00, 32'h0000_01fc, 32'h0bad_f00d, 2, 32'h0, 1'b0);
    op("ld_fc", 1'b0, 2'b00, 32'h0000_00fc, 32'h0, 2, 32'h0bad_f00d, 1'b0);
    op("ld_wrap", 1'b0, 2'b00, 32'hffff_ff10, 32'h0, 2, 32'h1234_ab78, 1'b0);

    // four back-to-back loads with req held high
    b2b_addr[0] = 32'h10; b2b_size[0] = 2'b00; b2b_exp[0] = 32'h1234_ab78;
    b2b_addr[1] = 32'h14; b2b_size[1] = 2'b00; b2b_exp[1] = 32'h5566_beef;
    b2b_addr[2] = 32'hfc; b2b_size[2] = 2'b00; b2b_exp[2] = 32'h0bad_f00d;
    b2b_addr[3] = 32'h16; b2b_size[3] = 2'b01; b2b_exp[3] = 32'h0000_beef;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = b2b_size[0]; address = b2b_addr[0];
    @(posedge clk);
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ready) begin
        if (n < 4) begin
          chk($sformatf("b2b%0d_cyc", n), c, 2 + 3 * n);
          chk($sformatf("b2b%0d_data", n), dataout, b2b_exp[n]);
        end
        n++;
        if (n < 4) begin
          size = b2b_size[n]; address = b2b_addr[n];
        end else begin
          req = 1'b0;
        end
      end
    end
    chk("b2b_count", n, 4);

    // reset while a byte store sits in MERGE
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b10; address = 32'h10; datain = 32'h0000_00ff;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'b0, ready}, 32'h0);
    chk("rst_mid_dout", dataout, 32'h0);
    req = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    chk("rst_mid_noready", n, 0);
    op("ld_after_rst", 1'b0, 2'b00, 32'h10, 32'h0, 2, 32'h1234_ab78, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
